// File: rtl/div_param_seq_pkg.sv
// Shared definitions for the iterative floating-point divider: FSM states and
// the exponent range check that is also used by the combinational multiplier.
package div_param_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {overflow, underflow} for a sign-extended biased exponent.
    // Overflow covers all-ones and anything beyond; negative means underflow.
    function automatic logic [1:0] exp_range_check(input int signed expo, input int unsigned m);
        int signed emax;
        emax = (32'sd1 <<< m) - 32'sd1;
        return {(expo >= emax), (expo < 32'sd0)};
    endfunction

endpackage

// File: rtl/div_param_seq_mant_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
module mant_div_step #(
    parameter int unsigned F = 23
) (
    input  logic [F+1:0] i_rem,
    input  logic [F:0]   i_div,
    output logic [F+1:0] o_rem,
    output logic         o_qbit
);

    logic [F:0] w_diff;

    // rem < 2*div always holds, so the difference and the unsubtracted
    // remainder both fit in F+1 bits before the shift.
    assign o_qbit = (i_rem >= {1'b0, i_div});
    assign w_diff = i_rem[F:0] - i_div;
    assign o_rem  = o_qbit ? {w_diff, 1'b0} : {i_rem[F:0], 1'b0};

endmodule

// File: rtl/div_param_seq.sv
// Iterative truncating floating-point divider, one quotient bit per clock,
// with valid/ready handshakes on operand and result sides.
module div_param_seq
    import div_param_seq_pkg::*;
#(
    parameter int unsigned n = 32,
    parameter int unsigned m = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out,
    output logic         overflow,
    output logic         underflow
);

    localparam int unsigned F  = n - m - 1;
    localparam int unsigned EW = m + 2;
    localparam int unsigned CW = $clog2(F + 2);
    localparam logic [EW-1:0] BIAS     = EW'(2 ** (m - 1) - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(F + 1);

    state_t        r_state;
    logic          r_sign;
    logic          r_a_zero;
    logic          r_b_zero;
    logic [EW-1:0] r_e;
    logic [F+1:0]  r_rem;
    logic [F:0]    r_div;
    logic [F:0]    r_q;
    logic [CW-1:0] r_cnt;
    logic [n-1:0]  r_out;
    logic          r_ovf;
    logic          r_unf;
    logic          r_in_ready;
    logic          r_out_valid;

    logic [F+1:0]  w_rem_next;
    logic          w_qbit;
    logic [F+1:0]  w_q_next;
    logic [F-1:0]  w_mant;
    logic [EW-1:0] w_expo;
    logic [EW-1:0] w_e_start;
    logic [1:0]    w_range;
    logic [n-1:0]  w_res_out;
    logic          w_res_ovf;
    logic          w_res_unf;

    mant_div_step #(.F(F)) u_step (
        .i_rem  (r_rem),
        .i_div  (r_div),
        .o_rem  (w_rem_next),
        .o_qbit (w_qbit)
    );

    assign w_e_start = {2'b00, a[n-2:F]} - {2'b00, b[n-2:F]} + BIAS;

    // The final quotient bit is produced in the same cycle the result is
    // registered, so normalisation works on the shifted-in value.
    assign w_q_next = {r_q, w_qbit};

    always_comb begin
        w_mant = w_q_next[F+1] ? w_q_next[F:1] : w_q_next[F-1:0];
        w_expo = w_q_next[F+1] ? r_e : r_e - EW'(1);
    end

    assign w_range = exp_range_check(int'(signed'(w_expo)), m);

    always_comb begin
        w_res_out = '0;
        w_res_ovf = 1'b0;
        w_res_unf = 1'b0;
        if (r_b_zero) begin
            w_res_ovf = 1'b1;
        end else if (!r_a_zero) begin
            if (w_range[1]) begin
                w_res_ovf = 1'b1;
            end else if (w_range[0]) begin
                w_res_unf = 1'b1;
            end else begin
                w_res_out = {r_sign, w_expo[m-1:0], w_mant};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sign      <= 1'b0;
            r_a_zero    <= 1'b0;
            r_b_zero    <= 1'b0;
            r_e         <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_out       <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign     <= a[n-1] ^ b[n-1];
                        r_a_zero   <= (a == '0);
                        r_b_zero   <= (b == '0);
                        r_e        <= w_e_start;
                        r_rem      <= {2'b01, a[F-1:0]};
                        r_div      <= {1'b1, b[F-1:0]};
                        r_q        <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= DIV;
                    end
                end
                DIV: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next[F:0];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_out       <= w_res_out;
                        r_ovf       <= w_res_ovf;
                        r_unf       <= w_res_unf;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_div_param_seq.sv
// Directed bench for div_param_seq (n=32, m=8): vector table plus handshake,
// backpressure and mid-operation reset sequences.
module tb_div_param_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dut_out;
    logic        overflow;
    logic        underflow;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[14];

    // Edges counted from and including the accept edge up to the edge that raises out_valid.
    localparam int LAT = 26;

    always #5 clk = ~clk;

    div_param_seq #(.n(32), .m(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dut_out),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    endtask

    task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_v);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0};
        vecs[2]  = '{32'hBF800000, 32'h3FC00000, 32'hBF2AAAAA, 1'b0, 1'b0};
        vecs[3]  = '{32'h7F000000, 32'h00800000, 32'h00000000, 1'b1, 1'b0};
        vecs[4]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b1};
        vecs[5]  = '{32'h40000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[6]  = '{32'h00000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0};
        vecs[7]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
        vecs[8]  = '{32'h7F000000, 32'h3F000000, 32'h00000000, 1'b1, 1'b0};
        vecs[9]  = '{32'h7F400000, 32'h3F800000, 32'h7F400000, 1'b0, 1'b0};
        vecs[10] = '{32'h00800000, 32'h3FC00000, 32'h002AAAAA, 1'b0, 1'b0};
        vecs[11] = '{32'h00800000, 32'h40400000, 32'h00000000, 1'b0, 1'b1};
        vecs[12] = '{32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0};
        vecs[13] = '{32'h40000000, 32'hC0000000, 32'hBF800000, 1'b0, 1'b0};

        #12;
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out",       dut_out,        32'h0);
        chk("reset_overflow",  32'(overflow),  32'd0);
        chk("reset_underflow", 32'(underflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            wait_result(lat);
            chk($sformatf("vec%0d_latency", i),   32'(lat),       32'(LAT));
            chk($sformatf("vec%0d_out", i),       dut_out,        vecs[i].q);
            chk($sformatf("vec%0d_overflow", i),  32'(overflow),  32'(vecs[i].ovf));
            chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].unf));
            handoff();
            chk($sformatf("vec%0d_handoff_valid", i), 32'(out_valid), 32'd0);
        end

        // Backpressure with ignored operand pulses, then back-to-back accept.
        start_op(32'h40C00000, 32'h40000000);
        wait_result(lat);
        chk("bp_latency", 32'(lat), 32'(LAT));
        chk("bp_out", dut_out, 32'h40400000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            a        = 32'h3F800000;
            b        = 32'h40400000;
            in_valid = (k % 2 == 0);
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_out", k),       dut_out,        32'h40400000);
            chk($sformatf("bp_hold%0d_in_ready", k),  32'(in_ready),  32'd0);
            chk($sformatf("bp_hold%0d_out_valid", k), 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        a         = 32'h3F800000;
        b         = 32'h40400000;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_in_ready",  32'(in_ready),  32'd1);
        chk("bp_release_out_kept",  dut_out,        32'h40400000);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_accepted", 32'(in_ready), 32'd0);
        wait_result(lat);
        chk("b2b_latency", 32'(lat), 32'(LAT));
        chk("b2b_out", dut_out, 32'h3EAAAAAA);
        handoff();
        held = dut_out;
        chk("b2b_out_kept_after_handoff", held, 32'h3EAAAAAA);

        // Asynchronous reset during the twelfth division cycle.
        start_op(32'h40C00000, 32'h40000000);
        repeat (11) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out",       dut_out,        32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_overflow",  32'(overflow),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("midrst_no_result", 32'(out_valid), 32'd0);
        start_op(32'h41200000, 32'h40A00000);
        wait_result(lat);
        chk("post_rst_latency", 32'(lat), 32'(LAT));
        chk("post_rst_out", dut_out, 32'h40000000);
        chk("post_rst_overflow", 32'(overflow), 32'd0);
        handoff();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
